net_iface: RTL

- Local-port network interface between a processing core and one router switch.
- TX path: accepts core messages on valid/ready, buffers them in a small FIFO, packs each into a bus word and drives the switch local-port input (index PORTS_NUM) through the wr_ready/r_ready handshake.
- RX path: unpacks words the switch delivers on its local output into a one-entry buffer presented to the core.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/iface_fifo.sv | 67 ++++++
 rtl/net_iface.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared bus-word layout helpers and TX FSM state type for the network interface.
package noc_pkg;

    localparam int DATA_LSB = 0;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_e;

    function automatic int bus_size(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

    function automatic int addr_lsb(input int data_size);
        return DATA_LSB + data_size;
    endfunction

    function automatic int valid_bit(input int data_size, input int addr_size);
        return bus_size(data_size, addr_size) - 1;
    endfunction

endpackage

// File: rtl/iface_fifo.sv
// Synchronous FIFO (depth 2**LOG2) with full/empty/count status; push is ignored when full.
module iface_fifo #(
    parameter int WIDTH = 36,
    parameter int LOG2  = 2
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LOG2:0]    count
);

    localparam int DEPTH = 2 ** LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOG2:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + LOG2'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + LOG2'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (LOG2 + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/net_iface.sv
// Local-port network interface: core TX FIFO -> switch, switch -> one-entry RX buffer.
// Define NET_IFACE_ADDR_CHECK_EN to drop misaddressed RX words and count them on misroute_cnt.
module net_iface
    import noc_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int ADDR      = 0,
    parameter int TX_LOG2   = 2,
    localparam int BUS_SIZE = bus_size(DATA_SIZE, ADDR_SIZE)
) (
    input  logic                 clk,
    input  logic                 a_rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [ADDR_SIZE-1:0] tx_addr,
    input  logic [DATA_SIZE-1:0] tx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [ADDR_SIZE-1:0] rx_addr,
    output logic [DATA_SIZE-1:0] rx_data,
    output logic                 sw_wr_ready_out,
    input  logic                 sw_r_ready_in,
    output logic [BUS_SIZE-1:0]  sw_data_o,
    input  logic                 sw_wr_ready_in,
    output logic                 sw_r_ready_out,
    input  logic [BUS_SIZE-1:0]  sw_data_i
`ifdef NET_IFACE_ADDR_CHECK_EN
    ,
    output logic [15:0]          misroute_cnt
`endif
);

    localparam int VB    = valid_bit(DATA_SIZE, ADDR_SIZE);
    localparam int AL    = addr_lsb(DATA_SIZE);
    localparam int DEPTH = 2 ** TX_LOG2;

    tx_state_e            state_q, state_d;
    logic [BUS_SIZE-1:0]  sw_data_q, sw_data_d;
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [BUS_SIZE-2:0]  fifo_head;
    logic [TX_LOG2:0]     fifo_count;

    iface_fifo #(
        .WIDTH (BUS_SIZE - 1),
        .LOG2  (TX_LOG2)
    ) u_tx_fifo (
        .clk   (clk),
        .a_rst (a_rst),
        .push  (tx_valid && tx_ready),
        .wdata ({tx_addr, tx_data}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;

    always_comb begin
        state_d   = state_q;
        sw_data_d = sw_data_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    sw_data_d = {1'b1, fifo_head};
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (sw_r_ready_in) begin
                    fifo_pop  = 1'b1;
                    sw_data_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                sw_data_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    assign sw_wr_ready_out = (state_q == SEND);
    assign sw_data_o       = sw_data_q;

    logic                 rx_full_q, rx_full_d;
    logic [ADDR_SIZE-1:0] rx_addr_q, rx_addr_d;
    logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
    logic [15:0]          misroute_q, misroute_d;
    logic                 capture, addr_hit;

    always_comb begin
        rx_full_d  = rx_full_q;
        rx_addr_d  = rx_addr_q;
        rx_data_d  = rx_data_q;
        misroute_d = misroute_q;
        capture    = sw_wr_ready_in && !rx_full_q;
`ifdef NET_IFACE_ADDR_CHECK_EN
        addr_hit   = (sw_data_i[AL +: ADDR_SIZE] == ADDR_SIZE'(ADDR));
`else
        addr_hit   = 1'b1;
`endif
        if (rx_full_q && rx_ready) begin
            rx_full_d = 1'b0;
        end
        if (capture && sw_data_i[VB]) begin
            if (addr_hit) begin
                rx_full_d = 1'b1;
                rx_addr_d = sw_data_i[AL +: ADDR_SIZE];
                rx_data_d = sw_data_i[DATA_LSB +: DATA_SIZE];
            end else if (misroute_q != '1) begin
                misroute_d = misroute_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q    <= IDLE;
            sw_data_q  <= '0;
            rx_full_q  <= 1'b0;
            rx_addr_q  <= '0;
            rx_data_q  <= '0;
            misroute_q <= '0;
        end else begin
            state_q    <= state_d;
            sw_data_q  <= sw_data_d;
            rx_full_q  <= rx_full_d;
            rx_addr_q  <= rx_addr_d;
            rx_data_q  <= rx_data_d;
            misroute_q <= misroute_d;
        end
    end

    // Gated by reset so every output except tx_ready reads 0 while a_rst is held.
    assign sw_r_ready_out = !rx_full_q && !a_rst;
    assign rx_valid       = rx_full_q;
    assign rx_addr        = rx_addr_q;
    assign rx_data        = rx_data_q;

`ifdef NET_IFACE_ADDR_CHECK_EN
    assign misroute_cnt = misroute_q;
`else
    logic unused_misroute;
    assign unused_misroute = ^misroute_q;
`endif

    count_matches_full: assert property (@(posedge clk) disable iff (a_rst)
        fifo_full == (fifo_count == (TX_LOG2 + 1)'(DEPTH)));

endmodule
